// File: rtl/timer_pkg.sv
// Shared encodings for the four-function timer core.
package timer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        PAUSE      = 3'd2,
        START_WAIT = 3'd3,
        CLEAR_WAIT = 3'd4,
        PAUSE_WAIT = 3'd5,
        DONE       = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MODE_UP0 = 2'd0,  // up from 0 to max
        MODE_UPP = 2'd1,  // up from preset to max
        MODE_DNM = 2'd2,  // down from max to 0
        MODE_DNP = 2'd3   // down from preset to 0
    } mode_e;

    // Both down modes share the upper mode bit.
    function automatic logic mode_is_down(logic [1:0] m);
        return m[1];
    endfunction

endpackage

// File: rtl/timer_ctrl_prescaler.sv
// Free-running clock divider; flags the last cycle of each count step.
module tick_prescaler #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned DIV_W = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_pulse
);

    localparam logic [DIV_W-1:0] Last = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance and wrap at DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_pulse = (cnt_q == Last);

endmodule

// File: rtl/timer_ctrl.sv
// Timer control core: button-handshake FSM plus prescaled up/down count datapath.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W   = 14,
    parameter int unsigned CNT_MAX = 9999,
    parameter int unsigned DIV     = 100000,
    parameter int unsigned DIV_W   = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   preset,
    output logic [CNT_W-1:0]   count,
    output logic [STATE_W-1:0] state,
    output logic               tick,
    output logic               done
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] preset_clamped;
    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] term_val;
    logic [CNT_W-1:0] count_step;
    logic             at_term;
    logic             run_active;
    logic             step;
    logic             ps_tick;

    tick_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .en         (run_active),
        .clr        (state_q == IDLE),
        .tick_pulse (ps_tick)
    );

    // Datapath helpers: reload value from live inputs, terminal/step from latched mode.
    always_comb begin
        preset_clamped = (preset > CntMax) ? CntMax : preset;
        case (mode)
            MODE_UP0: start_val = '0;
            MODE_UPP: start_val = preset_clamped;
            MODE_DNM: start_val = CntMax;
            default:  start_val = preset_clamped;
        endcase
        term_val   = mode_is_down(mode_q) ? '0 : CntMax;
        count_step = mode_is_down(mode_q) ? count_q - 1'b1 : count_q + 1'b1;
        at_term    = (count_q == term_val);
        // Prescaler only advances in RUN with no button action and count short of terminal.
        run_active = (state_q == RUN) && !clear && !start && !at_term;
        step       = run_active && ps_tick;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each button press waits for its release before acting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = START_WAIT;
            START_WAIT: if (!start) state_d = RUN;
            RUN: begin
                if (clear) begin
                    state_d = CLEAR_WAIT;
                end else if (start) begin
                    state_d = PAUSE_WAIT;
                end else if (at_term || (step && (count_step == term_val))) begin
                    state_d = DONE;
                end
            end
            PAUSE_WAIT: if (!start) state_d = PAUSE;
            PAUSE: begin
                if (clear) begin
                    state_d = CLEAR_WAIT;
                end else if (start) begin
                    state_d = START_WAIT;
                end
            end
            DONE:       if (clear) state_d = CLEAR_WAIT;
            CLEAR_WAIT: if (!clear) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values: reload in IDLE, step in RUN, hold elsewhere.
    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = start_val;
                if (start) mode_d = mode;
            end
            RUN: begin
                if (step) begin
                    count_d = count_step;
                    tick_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            mode_q  <= MODE_UP0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign tick  = tick_q;
    assign done  = (state_q == DONE);

endmodule
